// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, sync window bounds, counter and
// mode types, plus the mode wrap helper used by the frame scheduler.
package vga_timing_pkg;

    localparam int CLK_DIV = 4;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int N_MODES         = 4;
    localparam int MODE_W          = $clog2(N_MODES);
    localparam int FRAMES_PER_MODE = 60;
    localparam int CNT_W           = 11;

    typedef logic [MODE_W-1:0] mode_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Next pattern in round-robin order.
    function automatic mode_t mode_advance(input mode_t m);
        return (m == mode_t'(N_MODES - 1)) ? '0 : mode_t'(m + 1'b1);
    endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Raster bundle between the scan sequencer (slave) and its controller and
// pattern consumers (master).
interface vga_scan_ctrl_if;
    import vga_timing_pkg::*;

    logic  en;
    logic  mode_next;
    logic  pix_tick;
    cnt_t  hc;
    cnt_t  vc;
    logic  vidon;
    logic  hsync;
    logic  vsync;
    logic  frame_start;
    mode_t mode;

    modport master (
        output en, mode_next,
        input  pix_tick, hc, vc, vidon, hsync, vsync, frame_start, mode
    );

    modport slave (
        input  en, mode_next,
        output pix_tick, hc, vc, vidon, hsync, vsync, frame_start, mode
    );

endinterface

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: one pix_tick every CLK_DIV system clocks while
// enabled; the phase restarts from zero whenever en is low.
module vga_pix_div #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Divider phase counter, cleared by reset or when the raster is idle.
    // NOTE: sequential state uses <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign pix_tick = en && (div == DIV_LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster sequencer: pixel divider, hc/vc scan counters, registered
// vidon/hsync/vsync decode, frame_start pulse and the frame-aligned pattern
// scheduler. Define VGA_SCAN_AUTOCYCLE_EN to also advance mode automatically
// every FRAMES_PER_MODE frames.
module vga_scan_ctrl #(
    parameter int CLK_DIV         = vga_timing_pkg::CLK_DIV,
    parameter int H_VIS           = vga_timing_pkg::H_VIS,
    parameter int H_FP            = vga_timing_pkg::H_FP,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BP            = vga_timing_pkg::H_BP,
    parameter int V_VIS           = vga_timing_pkg::V_VIS,
    parameter int V_FP            = vga_timing_pkg::V_FP,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_BP            = vga_timing_pkg::V_BP,
    parameter int FRAMES_PER_MODE = vga_timing_pkg::FRAMES_PER_MODE
) (
    input  logic          clk,
    input  logic          rst,
    vga_scan_ctrl_if.slave scan
);
    import vga_timing_pkg::*;

    localparam cnt_t H_LAST   = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
    localparam cnt_t HS_FIRST = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam cnt_t VS_FIRST = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

    localparam int               FC_W    = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAMES_PER_MODE - 1);

    logic            pix_tick;
    cnt_t            hc, vc;
    cnt_t            hc_next, vc_next;
    logic            vidon, hsync, vsync;
    logic            frame_start;
    logic            restart;     // raster sits at (0,0) after reset or idle
    logic            boundary;    // this tick starts a new frame
    logic            advance;
    mode_t           mode;
    logic            pending;
    logic [FC_W-1:0] frame_cnt;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .en       (scan.en),
        .pix_tick (pix_tick)
    );

    // Next raster position: step on a pixel tick, wrap at line and frame end.
    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        hc_next = hc;
        vc_next = vc;
        if (pix_tick) begin
            if (hc == H_LAST) begin
                hc_next = '0;
                vc_next = (vc == V_LAST) ? '0 : cnt_t'(vc + 1'b1);
            end else begin
                hc_next = cnt_t'(hc + 1'b1);
            end
        end
    end

    // A frame begins on the tick that wraps to (0,0), or on the first tick
    // after the raster was restarted from (0,0).
    assign boundary = pix_tick && (restart || (hc == H_LAST && vc == V_LAST));

    // Mode advances on a pending request or, when enabled, on the auto period.
    always_comb begin
        advance = pending;
`ifdef VGA_SCAN_AUTOCYCLE_EN
        if (frame_cnt == FC_LAST) begin
            advance = 1'b1;
        end
`endif
    end

    // Scan counters plus sync/blank flags decoded from the next position.
    always_ff @(posedge clk) begin
        if (rst || !scan.en) begin
            hc          <= '0;
            vc          <= '0;
            vidon       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            restart     <= 1'b1;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            vidon       <= (hc_next < H_VIS_C) && (vc_next < V_VIS_C);
            hsync       <= !((hc_next >= HS_FIRST) && (hc_next <= HS_LAST));
            vsync       <= !((vc_next >= VS_FIRST) && (vc_next <= VS_LAST));
            frame_start <= boundary;
            if (pix_tick) begin
                restart <= 1'b0;
            end
        end
    end

    // Pattern scheduler: mode only moves on a frame boundary, at most once.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= '0;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else if (boundary) begin
            pending <= scan.mode_next;  // a request on the boundary waits a frame
            if (advance) begin
                mode      <= mode_advance(mode);
                frame_cnt <= '0;
            end else if (frame_cnt != FC_LAST) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end else if (scan.mode_next) begin
            pending <= 1'b1;
        end
    end

    assign scan.pix_tick    = pix_tick;
    assign scan.hc          = hc;
    assign scan.vc          = vc;
    assign scan.vidon       = vidon;
    assign scan.hsync       = hsync;
    assign scan.vsync       = vsync;
    assign scan.frame_start = frame_start;
    assign scan.mode        = mode;

endmodule
